vram_hdma: RTL and testbench
============================

# vram_hdma

Sequencer for CGB-style VRAM DMA (registers FF51–FF55). It copies 16-byte blocks from the cartridge/WRAM source bus into the 8 KB VRAM on behalf of the CPU. Transfers run either at once (general-purpose) or one block per LCD HBlank. It sits beside the video block and takes over the VRAM write port and cart/iram read path while active. `hdma_active` stalls the CPU.

## Interface
Parameters:
- `BYTE_CYCLES`, default 2: clocks per byte copied; minimum 2; read issued on first clock, write on last.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `cpu_sel` in 1: CPU address in FF51–FF55.
- `cpu_addr` in 3: FF51 (0) through FF55 (4); codes 5–7 unused.
- `cpu_wr` in 1: CPU write strobe.
- `cpu_di` in 8: CPU write data.
- `cpu_do` out 8: register read data.
- `lcd_mode` in 2: video mode; 0 means HBlank.
- `lcd_on` in 1: LCD enabled.
- `hdma_active` out 1: CPU stall request; owns source bus and VRAM write port.
- `src_addr` out 16: source byte address.
- `src_rd` out 1: source read strobe.
- `src_data` in 8: source data, valid the clock after `src_rd`.
- `vram_wr` out 1: VRAM write strobe.
- `vram_addr` out 13: VRAM byte offset.
- `vram_data` out 8: VRAM write data.

## Operation
- Shadow registers, writable at any time:
  - `src_hi` (FF51).
  - `src_lo[7:4]` (FF52); bits 3:0 ignored.
  - `dst_hi[4:0]` (FF53).
  - `dst_lo[7:4]` (FF54).
- Writing FF55 while IDLE starts a transfer:
  - Working counters load: `src_cnt` = {src_hi, src_lo[7:4], 0000}, `dst_cnt` = {dst_hi[4:0], dst_lo[7:4], 0000}, `blk_left` = `cpu_di[6:0]`.
  - Bit 7 = 0 selects general-purpose mode (GDMA); bit 7 = 1 selects HBlank mode (HDMA).
  - Transfer length = (`blk_left` + 1) × 16 bytes.
- FSM states:
  - IDLE
  - GDMA_RUN: all blocks back to back, then IDLE.
  - HB_WAIT: wait for a rising edge of (`lcd_mode`==0 && `lcd_on`), then HB_RUN.
  - HB_RUN: exactly 16 bytes, then HB_HOLD, or IDLE if it was the last block.
  - HB_HOLD: wait for `lcd_mode`≠0, then HB_WAIT.
- Byte step: `src_rd` = 1 with `src_addr` = `src_cnt`. One clock later `vram_wr` = 1 with `vram_addr` = `dst_cnt` and `vram_data` = `src_data`. Both counters then increment.
- Arithmetic:
  - `src_cnt` wraps at 16 bits.
  - `dst_cnt` wraps at 13 bits (1FFF→0000; the transfer continues).
  - `blk_left` decrements after each 16th byte; the final block is the one where `blk_left` = 0 before decrement.
- FF55 read values:
  - IDLE after a normal completion: FF.
  - Active: {0, `blk_left`}.
  - Terminated: {1, `blk_left`}.
  - FF51–FF54 read FF.
- Termination: a write to FF55 with bit 7 = 0 while in HB_WAIT or HB_HOLD goes to IDLE and latches the terminated flag. The same write in HB_RUN finishes the current block first, then terminates.
- Writes to FF55 during GDMA_RUN are ignored.
- Writes to FF51–FF54 during a transfer update the shadow registers only; the working counters are unaffected.

## Timing
- Reset: all outputs 0 except `cpu_do`, which reads FF on FF55. FSM goes to IDLE and shadow registers to 0. Reset mid-transfer aborts with no further strobes from the next clock.
- `hdma_active` rises the clock after the FF55 start write (GDMA) or after the HBlank edge (HDMA). It falls the clock after the final `vram_wr`.
- GDMA duration: 16 × (n+1) × `BYTE_CYCLES` clocks of `hdma_active`.
- HB_RUN: 16 × `BYTE_CYCLES` clocks per HBlank, first `src_rd` on the clock after the detected edge.
- An HBlank edge arriving during HB_RUN or HB_HOLD is ignored; at most one block per HBlank.
- With `lcd_on` = 0, HB_WAIT holds indefinitely; no blocks transfer.
- A CPU FF55 write and the completion of the last byte in the same clock: completion wins. The write is treated as a write to an IDLE block in the next clock only if repeated.

## Configuration
- `VRAM_HDMA_HBLANK_EN` defined: HBlank mode as described.
- `VRAM_HDMA_HBLANK_EN` undefined:
  - FF55 bit 7 is ignored; every transfer is GDMA.
  - HB_WAIT, HB_RUN and HB_HOLD do not exist.
  - `lcd_mode` and `lcd_on` are unused.
  - Terminated flag is never set.

## Test plan
- GDMA: FF51=C0, FF52=00, FF53=00, FF54=00, FF55=00 → 16 `vram_wr` at offsets 0000–000F with data from C000–C00F; `hdma_active` high 32 clocks (`BYTE_CYCLES`=2); FF55 then reads FF.
- HDMA: 3 blocks (FF55=82), toggle `lcd_mode` 3→0 three times → 16 writes per HBlank, `hdma_active` low between HBlanks; FF55 reads 01, then 00, then FF.
- Termination: FF55=85, one HBlank, then write FF55=00 in HB_HOLD → no further writes on later HBlanks; FF55 reads 84.
- Wrap: FF53=1F, FF54=F0, FF55=01 → 32 writes, `vram_addr` 1FF0–1FFF then 0000–000F.
- Reset asserted at byte 7 of GDMA → `hdma_active`, `src_rd` and `vram_wr` all 0 on the next clock; FF55 reads FF; a new GDMA starts cleanly.
- `lcd_on`=0 during HDMA (FF55=80) with `lcd_mode` toggling → zero writes; assert `lcd_on`=1 and an HBlank edge → 16 writes, then FF55 reads FF.

Source files
------------

// File: rtl/vram_hdma_if.sv
// Bus bundle for the VRAM DMA sequencer: CPU register port, LCD status,
// source read path and VRAM write port.
interface vram_hdma_if;
    logic        cpu_sel;
    logic [2:0]  cpu_addr;
    logic        cpu_wr;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do;
    logic [1:0]  lcd_mode;
    logic        lcd_on;
    logic        hdma_active;
    logic [15:0] src_addr;
    logic        src_rd;
    logic [7:0]  src_data;
    logic        vram_wr;
    logic [12:0] vram_addr;
    logic [7:0]  vram_data;

    modport slave (
        input  cpu_sel, cpu_addr, cpu_wr, cpu_di, lcd_mode, lcd_on, src_data,
        output cpu_do, hdma_active, src_addr, src_rd, vram_wr, vram_addr, vram_data
    );

    modport master (
        output cpu_sel, cpu_addr, cpu_wr, cpu_di, lcd_mode, lcd_on, src_data,
        input  cpu_do, hdma_active, src_addr, src_rd, vram_wr, vram_addr, vram_data
    );
endinterface

// File: rtl/vram_hdma.sv
// CGB-style VRAM DMA sequencer (FF51-FF55), copying 16-byte blocks into VRAM.
// Define VRAM_HDMA_HBLANK_EN to enable HBlank-paced transfers; otherwise all transfers are GDMA.
//
// state    | meaning
// IDLE     | no transfer; FF55 write starts one
// GDMA_RUN | all blocks back to back
// HB_WAIT  | waiting for a rising HBlank edge (lcd on, mode 0)
// HB_RUN   | copying one 16-byte block
// HB_HOLD  | block done, waiting for HBlank to end
module vram_hdma #(
    parameter int BYTE_CYCLES = 2
) (
    input  logic   clk,
    input  logic   reset,
    vram_hdma_if.slave bus
);
    localparam int PW = (BYTE_CYCLES > 2) ? $clog2(BYTE_CYCLES) : 1;
    localparam logic [PW-1:0] PH_LAST = PW'(BYTE_CYCLES - 1);
    localparam logic [PW-1:0] PH_PRE  = PW'(BYTE_CYCLES - 2);
    localparam logic [PW-1:0] PH_DATA = PW'(1);

`ifdef VRAM_HDMA_HBLANK_EN
    typedef enum logic [2:0] {IDLE, GDMA_RUN, HB_WAIT, HB_RUN, HB_HOLD} state_t;
`else
    typedef enum logic [0:0] {IDLE, GDMA_RUN} state_t;
`endif

    state_t          state_q;
    logic [7:0]      src_hi_q;
    logic [3:0]      src_lo_q;
    logic [4:0]      dst_hi_q;
    logic [3:0]      dst_lo_q;
    logic [15:0]     src_cnt_q;
    logic [12:0]     dst_cnt_q;
    logic [6:0]      blk_left_q;
    logic [3:0]      byte_idx_q;
    logic [PW-1:0]   phase_q;
    logic [7:0]      data_q;
    logic            term_q;
    logic            active_q;
    logic            src_rd_q;
    logic            vram_wr_q;

    logic [15:0]     src_cnt_d;
    logic [12:0]     dst_cnt_d;
    logic [6:0]      blk_left_d;
    logic            ff55_wr;
    logic            byte_end;
    logic            blk_end;
    logic            last_blk;
    logic            running;
    logic [7:0]      ff55_val;

    assign src_cnt_d  = src_cnt_q + 16'd1;
    assign dst_cnt_d  = dst_cnt_q + 13'd1;
    assign blk_left_d = blk_left_q - 7'd1;
    assign ff55_wr    = bus.cpu_sel & bus.cpu_wr & (bus.cpu_addr == 3'd4);
    assign byte_end   = (phase_q == PH_LAST);
    assign blk_end    = byte_end & (byte_idx_q == 4'hF);
    assign last_blk   = (blk_left_q == 7'd0);

`ifdef VRAM_HDMA_HBLANK_EN
    logic hb_prev_q;
    logic term_req_q;
    logic hb_now;
    logic ff55_stop;
    assign hb_now    = (bus.lcd_mode == 2'd0) & bus.lcd_on;
    assign ff55_stop = ff55_wr & ~bus.cpu_di[7];
    assign running   = (state_q == GDMA_RUN) | (state_q == HB_RUN);
`else
    assign running   = (state_q == GDMA_RUN);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            src_hi_q   <= '0;
            src_lo_q   <= '0;
            dst_hi_q   <= '0;
            dst_lo_q   <= '0;
            src_cnt_q  <= '0;
            dst_cnt_q  <= '0;
            blk_left_q <= '0;
            byte_idx_q <= '0;
            phase_q    <= '0;
            data_q     <= '0;
            term_q     <= 1'b0;
            active_q   <= 1'b0;
            src_rd_q   <= 1'b0;
            vram_wr_q  <= 1'b0;
`ifdef VRAM_HDMA_HBLANK_EN
            hb_prev_q  <= 1'b0;
            term_req_q <= 1'b0;
`endif
        end else begin
            if (bus.cpu_sel && bus.cpu_wr) begin
                case (bus.cpu_addr)
                    3'd0:    src_hi_q <= bus.cpu_di;
                    3'd1:    src_lo_q <= bus.cpu_di[7:4];
                    3'd2:    dst_hi_q <= bus.cpu_di[4:0];
                    3'd3:    dst_lo_q <= bus.cpu_di[7:4];
                    default: ;
                endcase
            end
`ifdef VRAM_HDMA_HBLANK_EN
            hb_prev_q <= hb_now;
`endif
            src_rd_q  <= 1'b0;
            vram_wr_q <= 1'b0;

            // Byte engine: read on phase 0, write on the last phase.
            if (running) begin
                if (phase_q == PH_DATA) data_q <= bus.src_data;
                if (byte_end) begin
                    phase_q    <= '0;
                    src_cnt_q  <= src_cnt_d;
                    dst_cnt_q  <= dst_cnt_d;
                    byte_idx_q <= byte_idx_q + 4'd1;
                    src_rd_q   <= ~blk_end;
                end else begin
                    phase_q   <= phase_q + PW'(1);
                    vram_wr_q <= (phase_q == PH_PRE);
                end
            end

            case (state_q)
                IDLE: begin
                    if (ff55_wr) begin
                        src_cnt_q  <= {src_hi_q, src_lo_q, 4'h0};
                        dst_cnt_q  <= {dst_hi_q, dst_lo_q, 4'h0};
                        blk_left_q <= bus.cpu_di[6:0];
                        term_q     <= 1'b0;
                        phase_q    <= '0;
                        byte_idx_q <= '0;
`ifdef VRAM_HDMA_HBLANK_EN
                        term_req_q <= 1'b0;
                        if (bus.cpu_di[7]) begin
                            state_q <= HB_WAIT;
                        end else begin
                            state_q  <= GDMA_RUN;
                            active_q <= 1'b1;
                            src_rd_q <= 1'b1;
                        end
`else
                        state_q  <= GDMA_RUN;
                        active_q <= 1'b1;
                        src_rd_q <= 1'b1;
`endif
                    end
                end
                GDMA_RUN: begin
                    if (blk_end) begin
                        if (last_blk) begin
                            state_q  <= IDLE;
                            active_q <= 1'b0;
                        end else begin
                            blk_left_q <= blk_left_d;
                            src_rd_q   <= 1'b1;
                        end
                    end
                end
`ifdef VRAM_HDMA_HBLANK_EN
                HB_WAIT: begin
                    if (ff55_stop) begin
                        state_q <= IDLE;
                        term_q  <= 1'b1;
                    end else if (hb_now && !hb_prev_q) begin
                        state_q    <= HB_RUN;
                        active_q   <= 1'b1;
                        src_rd_q   <= 1'b1;
                        phase_q    <= '0;
                        byte_idx_q <= '0;
                    end
                end
                HB_RUN: begin
                    if (ff55_stop) term_req_q <= 1'b1;
                    if (blk_end) begin
                        active_q <= 1'b0;
                        if (last_blk) begin
                            state_q <= IDLE;
                        end else begin
                            blk_left_q <= blk_left_d;
                            if (term_req_q || ff55_stop) begin
                                state_q <= IDLE;
                                term_q  <= 1'b1;
                            end else begin
                                state_q <= HB_HOLD;
                            end
                        end
                    end
                end
                HB_HOLD: begin
                    if (ff55_stop) begin
                        state_q <= IDLE;
                        term_q  <= 1'b1;
                    end else if (bus.lcd_mode != 2'd0) begin
                        state_q <= HB_WAIT;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        ff55_val = {1'b0, blk_left_q};
        if (state_q == IDLE) ff55_val = term_q ? {1'b1, blk_left_q} : 8'hFF;
    end

    assign bus.cpu_do      = !bus.cpu_sel ? 8'h00 : ((bus.cpu_addr == 3'd4) ? ff55_val : 8'hFF);
    assign bus.hdma_active = active_q;
    assign bus.src_rd      = src_rd_q;
    assign bus.src_addr    = src_cnt_q;
    assign bus.vram_wr     = vram_wr_q;
    assign bus.vram_addr   = dst_cnt_q;
    // With two clocks per byte the source byte arrives in the write clock itself.
    assign bus.vram_data   = vram_wr_q ? ((phase_q == PH_DATA) ? bus.src_data : data_q) : 8'h00;
endmodule

// File: tb/tb_vram_hdma.sv
// Directed bench for vram_hdma: register table, GDMA transfer table and
// hand-written sequences for reset, collisions and HBlank pacing.
module tb_vram_hdma;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vram_hdma_if hif();
    vram_hdma dut (.clk(clk), .reset(reset), .bus(hif));

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [7:0] src_model(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction

    always @(posedge clk) hif.src_data <= hif.src_rd ? src_model(hif.src_addr) : 8'hEE;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [15:0] exp_rd_addr, exp_wr_src;
    logic [12:0] exp_wr_dst;
    int wr_count, rd_count, act_cnt;
    logic prev_rd = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (hif.hdma_active) act_cnt++;
            if (hif.src_rd) begin
                check("src_addr", hif.src_addr, exp_rd_addr);
                check("rd_while_active", hif.hdma_active, 1);
                exp_rd_addr++;
                rd_count++;
            end
            if (hif.vram_wr) begin
                check("vram_addr", hif.vram_addr, exp_wr_dst);
                check("vram_data", hif.vram_data, src_model(exp_wr_src));
                check("wr_follows_rd", prev_rd, 1);
                exp_wr_dst++;
                exp_wr_src++;
                wr_count++;
            end
        end
        prev_rd = hif.src_rd;
    end

    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        hif.cpu_sel = 1'b1; hif.cpu_wr = 1'b1; hif.cpu_addr = a; hif.cpu_di = d;
        @(negedge clk);
        hif.cpu_sel = 1'b0; hif.cpu_wr = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [7:0] exp);
        @(negedge clk);
        hif.cpu_sel = 1'b1; hif.cpu_wr = 1'b0; hif.cpu_addr = a;
        #1 check(name, hif.cpu_do, exp);
        hif.cpu_sel = 1'b0;
    endtask

    task automatic arm(input logic [15:0] s, input logic [12:0] d);
        exp_rd_addr = s; exp_wr_src = s; exp_wr_dst = d;
        wr_count = 0; rd_count = 0; act_cnt = 0;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            #1 if (!hif.hdma_active) done = 1'b1;
        end
        check("wait_idle_in_budget", done, 1);
    endtask

    task automatic setup_regs(input logic [7:0] sh, sl, dh, dl);
        cpu_write(3'd0, sh); cpu_write(3'd1, sl); cpu_write(3'd2, dh); cpu_write(3'd3, dl);
    endtask

    typedef struct {
        logic        sel;
        logic [2:0]  addr;
        logic [7:0]  e_do;
    } rd_t;

    typedef struct {
        logic [7:0]  s_hi, s_lo, d_hi, d_lo, ctl;
        logic [15:0] e_src;
        logic [12:0] e_dst;
        int          e_wr;
        int          e_act;
    } xfer_t;

    rd_t   rt[6];
    xfer_t xt[4];

    task automatic run_xfer(input int k);
        setup_regs(xt[k].s_hi, xt[k].s_lo, xt[k].d_hi, xt[k].d_lo);
        arm(xt[k].e_src, xt[k].e_dst);
        cpu_write(3'd4, xt[k].ctl);
        check("start_active", hif.hdma_active, 1);
        wait_idle(2000);
        check("xfer_writes", wr_count, xt[k].e_wr);
        check("xfer_reads", rd_count, xt[k].e_wr);
        check("xfer_active_clks", act_cnt, xt[k].e_act);
        read_check("ff55_after_gdma", 3'd4, 8'hFF);
    endtask

`ifdef VRAM_HDMA_HBLANK_EN
    logic [7:0] hb_exp[3];
    int wr_before;
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rt[0] = '{1'b1, 3'd0, 8'hFF};
        rt[1] = '{1'b1, 3'd1, 8'hFF};
        rt[2] = '{1'b1, 3'd2, 8'hFF};
        rt[3] = '{1'b1, 3'd3, 8'hFF};
        rt[4] = '{1'b1, 3'd4, 8'hFF};
        rt[5] = '{1'b0, 3'd4, 8'h00};
        xt[0] = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 16'hC000, 13'h0000, 16, 32};
        xt[1] = '{8'hD0, 8'h00, 8'h1F, 8'hF0, 8'h01, 16'hD000, 13'h1FF0, 32, 64};
        xt[2] = '{8'h12, 8'h3F, 8'hE5, 8'h4C, 8'h02, 16'h1230, 13'h0540, 48, 96};
        xt[3] = '{8'hFF, 8'hF0, 8'h00, 8'h20, 8'h01, 16'hFFF0, 13'h0020, 32, 64};

        reset = 1'b1;
        hif.cpu_sel = 1'b0; hif.cpu_wr = 1'b0; hif.cpu_addr = 3'd0; hif.cpu_di = 8'h00;
        hif.lcd_mode = 2'd3; hif.lcd_on = 1'b1;
        arm(16'h0, 13'h0);
        repeat (3) @(negedge clk);
        check("rst_active", hif.hdma_active, 0);
        check("rst_src_rd", hif.src_rd, 0);
        check("rst_vram_wr", hif.vram_wr, 0);
        check("rst_src_addr", hif.src_addr, 0);
        check("rst_vram_addr", hif.vram_addr, 0);
        check("rst_vram_data", hif.vram_data, 0);
        reset = 1'b0;

        foreach (rt[i]) begin
            @(negedge clk);
            hif.cpu_sel = rt[i].sel; hif.cpu_wr = 1'b0; hif.cpu_addr = rt[i].addr;
            #1 check($sformatf("reg_read_%0d", i), hif.cpu_do, rt[i].e_do);
            hif.cpu_sel = 1'b0;
        end

        for (int k = 0; k < 4; k++) run_xfer(k);

        // FF55 and shadow writes during GDMA must not disturb the running copy.
        setup_regs(8'hC0, 8'h00, 8'h00, 8'h00);
        arm(16'hC000, 13'h0000);
        cpu_write(3'd4, 8'h01);
        repeat (10) @(negedge clk);
        cpu_write(3'd4, 8'h05);
        cpu_write(3'd0, 8'h55);
        wait_idle(2000);
        check("ignored_wr_writes", wr_count, 32);
        check("ignored_wr_active", act_cnt, 64);
        read_check("ignored_wr_ff55", 3'd4, 8'hFF);

        // FF55 write landing on the final-byte clock: completion wins.
        setup_regs(8'hC0, 8'h00, 8'h00, 8'h00);
        arm(16'hC000, 13'h0000);
        cpu_write(3'd4, 8'h00);
        repeat (30) @(negedge clk);
        cpu_write(3'd4, 8'h00);
        #1 check("collide_active", hif.hdma_active, 0);
        check("collide_writes", wr_count, 16);
        read_check("collide_ff55", 3'd4, 8'hFF);

        // Reset in the middle of a GDMA.
        arm(16'hC000, 13'h0000);
        cpu_write(3'd4, 8'h00);
        for (int i = 0; i < 200 && wr_count < 7; i++) begin
            @(negedge clk);
            #1;
        end
        check("mid_reset_reached", wr_count, 7);
        reset = 1'b1;
        @(negedge clk);
        check("mid_reset_active", hif.hdma_active, 0);
        check("mid_reset_src_rd", hif.src_rd, 0);
        check("mid_reset_vram_wr", hif.vram_wr, 0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_reset_no_more_wr", wr_count, 7);
        read_check("mid_reset_ff55", 3'd4, 8'hFF);
        run_xfer(0);

`ifndef VRAM_HDMA_HBLANK_EN
        // Without HBlank support bit 7 is ignored: 0x82 is a 3-block GDMA.
        setup_regs(8'hC0, 8'h00, 8'h00, 8'h00);
        arm(16'hC000, 13'h0000);
        cpu_write(3'd4, 8'h82);
        check("nohb_start_active", hif.hdma_active, 1);
        wait_idle(2000);
        check("nohb_writes", wr_count, 48);
        check("nohb_active", act_cnt, 96);
        read_check("nohb_ff55", 3'd4, 8'hFF);
`else
        hb_exp[0] = 8'h01; hb_exp[1] = 8'h00; hb_exp[2] = 8'hFF;
        setup_regs(8'hC0, 8'h00, 8'h00, 8'h00);
        arm(16'hC000, 13'h0000);
        hif.lcd_mode = 2'd3;
        cpu_write(3'd4, 8'h82);
        check("hb_wait_inactive", hif.hdma_active, 0);
        read_check("hb_ff55_pending", 3'd4, 8'h02);
        repeat (5) @(negedge clk);
        check("hb_no_early_writes", wr_count, 0);
        for (int b = 0; b < 3; b++) begin
            wr_before = wr_count;
            act_cnt = 0;
            @(negedge clk);
            hif.lcd_mode = 2'd0;
            @(negedge clk);
            #1 check("hb_active_rise", hif.hdma_active, 1);
            wait_idle(2000);
            check("hb_block_writes", wr_count - wr_before, 16);
            check("hb_block_active", act_cnt, 32);
            repeat (8) @(negedge clk);
            check("hb_one_block_per_hblank", wr_count - wr_before, 16);
            read_check("hb_ff55_progress", 3'd4, hb_exp[b]);
            hif.lcd_mode = 2'd3;
            repeat (3) @(negedge clk);
        end

        // Termination from HB_HOLD.
        arm(16'hC000, 13'h0000);
        cpu_write(3'd4, 8'h85);
        @(negedge clk);
        hif.lcd_mode = 2'd0;
        @(negedge clk);
        wait_idle(2000);
        check("term_first_block", wr_count, 16);
        cpu_write(3'd4, 8'h00);
        read_check("term_ff55", 3'd4, 8'h84);
        for (int b = 0; b < 2; b++) begin
            hif.lcd_mode = 2'd3;
            repeat (3) @(negedge clk);
            hif.lcd_mode = 2'd0;
            repeat (40) @(negedge clk);
        end
        check("term_no_more_writes", wr_count, 16);
        check("term_inactive", hif.hdma_active, 0);
        read_check("term_ff55_hold", 3'd4, 8'h84);

        // LCD off: HBlank edges are invisible until it is switched on.
        hif.lcd_mode = 2'd3;
        hif.lcd_on = 1'b0;
        arm(16'hC000, 13'h0000);
        cpu_write(3'd4, 8'h80);
        for (int b = 0; b < 3; b++) begin
            hif.lcd_mode = 2'd3;
            repeat (4) @(negedge clk);
            hif.lcd_mode = 2'd0;
            repeat (40) @(negedge clk);
        end
        check("lcdoff_writes", wr_count, 0);
        check("lcdoff_inactive", hif.hdma_active, 0);
        read_check("lcdoff_ff55", 3'd4, 8'h00);
        hif.lcd_mode = 2'd3;
        hif.lcd_on = 1'b1;
        repeat (3) @(negedge clk);
        hif.lcd_mode = 2'd0;
        @(negedge clk);
        #1 check("lcdon_active_rise", hif.hdma_active, 1);
        wait_idle(2000);
        check("lcdon_writes", wr_count, 16);
        read_check("lcdon_ff55", 3'd4, 8'hFF);
        hif.lcd_mode = 2'd3;
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
